// File: rtl/ball_pkg.sv
// ball_pkg: shared game types and playfield constants.
// Used by ball_ctrl and ball_collide.
package ball_pkg;

  typedef enum logic [1:0] {
    ST_SERVE = 2'd0,
    ST_PLAY  = 2'd1,
    ST_OVER  = 2'd2
  } state_t;

  localparam int DEF_SCREEN_W = 640;
  localparam int DEF_SCREEN_H = 480;
  localparam int DEF_PADDLE_Y = 460;

  // Signed velocity component, -2..+2.
  typedef logic signed [2:0] vel_t;

  localparam vel_t V_POS1 = 3'sd1;
  localparam vel_t V_NEG1 = -3'sd1;
  localparam vel_t V_POS2 = 3'sd2;
  localparam vel_t V_NEG2 = -3'sd2;

  // Working width for position arithmetic.
  typedef logic signed [11:0] s12_t;

  function automatic s12_t sx12(input logic [9:0] v);
    return s12_t'({2'b00, v});
  endfunction

  function automatic s12_t vx12(input vel_t v);
    return {{9{v[2]}}, v};
  endfunction

endpackage

// File: rtl/ball_collide.sv
// ball_collide: next ball position, wall/paddle reflection, exit.
// Macro BALL_ANGLE_EN: outer-quarter paddle hits give |dx| = 2.
module ball_collide
  import ball_pkg::*;
#(
  parameter int SCREEN_W  = DEF_SCREEN_W,
  parameter int SCREEN_H  = DEF_SCREEN_H,
  parameter int BALL_SIZE = 8,
  parameter int PADDLE_Y  = DEF_PADDLE_Y
) (
  input  logic [9:0] i_x,
  input  logic [9:0] i_y,
  input  vel_t       i_dx,
  input  vel_t       i_dy,
  input  logic [9:0] i_paddle_x,
  input  logic [9:0] i_paddle_width,
  output logic [9:0] o_nx,
  output logic [9:0] o_ny,
  output vel_t       o_dx,
  output vel_t       o_dy,
  output logic       o_hit,
  output logic       o_exit
);

  localparam s12_t XMAX  = s12_t'(SCREEN_W - BALL_SIZE);
  localparam s12_t YEXIT = s12_t'(SCREEN_H - BALL_SIZE);
  localparam s12_t YREST = s12_t'(PADDLE_Y - BALL_SIZE);
  localparam s12_t PY    = s12_t'(PADDLE_Y);
  localparam s12_t BSZ   = s12_t'(BALL_SIZE);

  s12_t w_x;
  s12_t w_y;
  s12_t w_px;
  s12_t w_pr;
  s12_t w_nx0;
  s12_t w_ny0;
  s12_t w_nx;
  s12_t w_ny;
  vel_t w_mag;
  logic w_hit;

  assign w_x   = sx12(i_x);
  assign w_y   = sx12(i_y);
  assign w_px  = sx12(i_paddle_x);
  // Right edge summed wide so it cannot wrap.
  assign w_pr  = w_px + sx12(i_paddle_width);
  assign w_nx0 = w_x + vx12(i_dx);
  assign w_ny0 = w_y + vx12(i_dy);
  assign w_mag = i_dx[2] ? -i_dx : i_dx;

  // Crossing the paddle line while descending and overlapping it.
  assign w_hit = (i_dy == V_POS1)
              && ((w_y + BSZ) <= PY)
              && (PY < (w_ny0 + BSZ))
              && ((w_x + BSZ) > w_px)
              && (w_x < w_pr);

`ifdef BALL_ANGLE_EN
  s12_t w_pw;
  s12_t w_q;
  s12_t w_off;

  assign w_pw  = sx12(i_paddle_width);
  assign w_q   = w_pw >>> 2;
  // Ball centre relative to the paddle's left edge.
  assign w_off = w_x + (BSZ >>> 1) - w_px;
`endif

  // Walls first, then the paddle; both may apply in one step.
  always_comb begin
    w_nx   = w_nx0;
    w_ny   = w_ny0;
    o_dx   = i_dx;
    o_dy   = i_dy;
    o_hit  = 1'b0;
    o_exit = 1'b0;
    if (w_nx0 < 0) begin
      w_nx = '0;
      o_dx = w_mag;
    end else if (w_nx0 > XMAX) begin
      w_nx = XMAX;
      o_dx = -w_mag;
    end
    if (w_ny0 < 0) begin
      w_ny = '0;
      o_dy = V_POS1;
    end
    if (w_hit) begin
      o_hit = 1'b1;
      w_ny  = YREST;
      o_dy  = V_NEG1;
`ifdef BALL_ANGLE_EN
      if (w_off < w_q) begin
        o_dx = V_NEG2;
      end else if (w_off >= (w_pw - w_q)) begin
        o_dx = V_POS2;
      end else begin
        o_dx = o_dx[2] ? V_NEG1 : V_POS1;
      end
`endif
    end else if (w_ny >= YEXIT) begin
      o_exit = 1'b1;
    end
    o_nx = w_nx[9:0];
    o_ny = w_ny[9:0];
  end

endmodule

// File: rtl/ball_ctrl.sv
// ball_ctrl: serve/play/over rally FSM, ball registers and lives.
// Macro BALL_ANGLE_EN: paddle-position dependent |dx| (in ball_collide).
module ball_ctrl
  import ball_pkg::*;
#(
  parameter int SCREEN_W  = DEF_SCREEN_W,
  parameter int SCREEN_H  = DEF_SCREEN_H,
  parameter int BALL_SIZE = 8,
  parameter int PADDLE_Y  = DEF_PADDLE_Y,
  parameter int LIVES     = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       pause,
  input  logic       launch,
  input  logic [9:0] paddle_x,
  input  logic [9:0] paddle_width,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [1:0] lives,
  output logic [1:0] state,
  output logic       bounce,
  output logic       miss
);

  localparam logic [9:0] X_RST  = 10'(SCREEN_W / 2 - BALL_SIZE / 2);
  localparam logic [9:0] Y_REST = 10'(PADDLE_Y - BALL_SIZE);
  localparam logic [9:0] X_MAX  = 10'(SCREEN_W - BALL_SIZE);
  localparam s12_t       XMAX_S = s12_t'(SCREEN_W - BALL_SIZE);
  localparam s12_t       HALF_B = s12_t'(BALL_SIZE / 2);
  localparam logic [1:0] LV_RST = 2'(LIVES);

  state_t     r_state;
  logic [9:0] r_x;
  logic [9:0] r_y;
  vel_t       r_dx;
  vel_t       r_dy;
  logic [1:0] r_lives;
  logic       r_bounce;
  logic       r_miss;

  state_t     w_state_nx;
  logic [9:0] w_x_nx;
  logic [9:0] w_y_nx;
  vel_t       w_dx_nx;
  vel_t       w_dy_nx;
  logic [1:0] w_lives_nx;
  logic       w_bounce_nx;
  logic       w_miss_nx;

  s12_t       w_sx;
  logic [9:0] w_serve_x;
  logic [9:0] w_cnx;
  logic [9:0] w_cny;
  vel_t       w_cdx;
  vel_t       w_cdy;
  logic       w_hit;
  logic       w_exit;

  // Serve position: ball centred on the paddle, kept on screen.
  assign w_sx = sx12(paddle_x)
              + sx12({1'b0, paddle_width[9:1]})
              - HALF_B;
  assign w_serve_x = (w_sx < 0)      ? '0    :
                     (w_sx > XMAX_S) ? X_MAX :
                                       w_sx[9:0];

  ball_collide #(
    .SCREEN_W  (SCREEN_W),
    .SCREEN_H  (SCREEN_H),
    .BALL_SIZE (BALL_SIZE),
    .PADDLE_Y  (PADDLE_Y)
  ) u_collide (
    .i_x            (r_x),
    .i_y            (r_y),
    .i_dx           (r_dx),
    .i_dy           (r_dy),
    .i_paddle_x     (paddle_x),
    .i_paddle_width (paddle_width),
    .o_nx           (w_cnx),
    .o_ny           (w_cny),
    .o_dx           (w_cdx),
    .o_dy           (w_cdy),
    .o_hit          (w_hit),
    .o_exit         (w_exit)
  );

  // State register and ball/lives registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_SERVE;
      r_x      <= X_RST;
      r_y      <= Y_REST;
      r_dx     <= V_POS1;
      r_dy     <= V_NEG1;
      r_lives  <= LV_RST;
      r_bounce <= 1'b0;
      r_miss   <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_x      <= w_x_nx;
      r_y      <= w_y_nx;
      r_dx     <= w_dx_nx;
      r_dy     <= w_dy_nx;
      r_lives  <= w_lives_nx;
      r_bounce <= w_bounce_nx;
      r_miss   <= w_miss_nx;
    end
  end

  // Next state and datapath; pause freezes everything.
  always_comb begin
    w_state_nx  = r_state;
    w_x_nx      = r_x;
    w_y_nx      = r_y;
    w_dx_nx     = r_dx;
    w_dy_nx     = r_dy;
    w_lives_nx  = r_lives;
    w_bounce_nx = 1'b0;
    w_miss_nx   = 1'b0;
    if (!pause) begin
      unique case (r_state)
        ST_SERVE: begin
          w_x_nx = w_serve_x;
          w_y_nx = Y_REST;
          if (launch) begin
            w_state_nx = ST_PLAY;
            w_dx_nx    = V_POS1;
            w_dy_nx    = V_NEG1;
          end
        end
        ST_PLAY: begin
          if (tick) begin
            w_x_nx      = w_cnx;
            w_y_nx      = w_cny;
            w_dx_nx     = w_cdx;
            w_dy_nx     = w_cdy;
            w_bounce_nx = w_hit;
            if (w_exit) begin
              w_miss_nx  = 1'b1;
              w_lives_nx = r_lives - 2'd1;
              w_state_nx = (r_lives == 2'd1) ? ST_OVER : ST_SERVE;
              w_dx_nx    = V_POS1;
              w_dy_nx    = V_NEG1;
            end
          end
        end
        ST_OVER: begin
          w_state_nx = ST_OVER;
        end
        default: begin
          w_state_nx = ST_SERVE;
        end
      endcase
    end
  end

  assign ball_x = r_x;
  assign ball_y = r_y;
  assign lives  = r_lives;
  assign state  = r_state;
  assign bounce = r_bounce;
  assign miss   = r_miss;

endmodule

// File: tb/tb_ball_ctrl.sv
// tb_ball_ctrl: self-checking bench for ball_ctrl.
// Serve table plus scoreboarded rally sequences against a behavioural model.
module tb_ball_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick;
  logic       pause;
  logic       launch;
  logic [9:0] paddle_x;
  logic [9:0] paddle_width;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic [1:0] lives;
  logic [1:0] state;
  logic       bounce;
  logic       miss;

  ball_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .tick         (tick),
    .pause        (pause),
    .launch       (launch),
    .paddle_x     (paddle_x),
    .paddle_width (paddle_width),
    .ball_x       (ball_x),
    .ball_y       (ball_y),
    .lives        (lives),
    .state        (state),
    .bounce       (bounce),
    .miss         (miss)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    int lv;
    int st;
    int bn;
    int ms;
  } exp_t;

  typedef struct {
    int px;
    int pw;
    int ex;
  } srv_t;

  exp_t sbq[$];
  int checks = 0;
  int errors = 0;

  int m_x, m_y, m_dx, m_dy, m_lv, m_st, m_bn, m_ms;
  int g_px = 0;
  int g_pw = 64;

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", n, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_x  = 316;
    m_y  = 452;
    m_dx = 1;
    m_dy = -1;
    m_lv = 3;
    m_st = 0;
    m_bn = 0;
    m_ms = 0;
  endtask

  task automatic model_step(input bit t, input bit p, input bit l,
                            input int px, input int pw);
    int nx, ny, ndx, ndy, mag, c;
    bit hit;
    m_bn = 0;
    m_ms = 0;
    if (!p) begin
      if (m_st == 0) begin
        c = px + pw / 2 - 4;
        if (c < 0) c = 0;
        if (c > 632) c = 632;
        m_x = c;
        m_y = 452;
        if (l) begin
          m_st = 1;
          m_dx = 1;
          m_dy = -1;
        end
      end else if (m_st == 1 && t) begin
        nx  = m_x + m_dx;
        ny  = m_y + m_dy;
        ndx = m_dx;
        ndy = m_dy;
        mag = (m_dx < 0) ? -m_dx : m_dx;
        if (nx < 0) begin
          nx  = 0;
          ndx = mag;
        end
        if (nx > 632) begin
          nx  = 632;
          ndx = -mag;
        end
        if (ny < 0) begin
          ny  = 0;
          ndy = 1;
        end
        hit = (m_dy == 1) && (m_y + 8 <= 460) && (460 < ny + 8)
           && (m_x + 8 > px) && (m_x < px + pw);
        if (hit) begin
          ny   = 452;
          ndy  = -1;
          m_bn = 1;
`ifdef BALL_ANGLE_EN
          c = m_x + 4 - px;
          if (c < pw / 4) ndx = -2;
          else if (c >= pw - pw / 4) ndx = 2;
          else ndx = (ndx < 0) ? -1 : 1;
`endif
        end else if (ny >= 472) begin
          m_ms = 1;
          m_lv = m_lv - 1;
          m_st = (m_lv == 0) ? 2 : 0;
          ndx  = 1;
          ndy  = -1;
        end
        m_x  = nx;
        m_y  = ny;
        m_dx = ndx;
        m_dy = ndy;
      end
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_x"}, ball_x, 316);
    chk({tag, "_y"}, ball_y, 452);
    chk({tag, "_lives"}, lives, 3);
    chk({tag, "_state"}, state, 0);
    chk({tag, "_bounce"}, bounce, 0);
    chk({tag, "_miss"}, miss, 0);
  endtask

  // Drive one cycle, queue the model's expectation, compare after the edge.
  task automatic step(input bit t, input bit p, input bit l,
                      input int px, input int pw);
    exp_t e;
    tick         = t;
    pause        = p;
    launch       = l;
    paddle_x     = 10'(px);
    paddle_width = 10'(pw);
    model_step(t, p, l, px, pw);
    e = '{m_x, m_y, m_lv, m_st, m_bn, m_ms};
    sbq.push_back(e);
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    chk("sb_x", ball_x, e.x);
    chk("sb_y", ball_y, e.y);
    chk("sb_lives", lives, e.lv);
    chk("sb_state", state, e.st);
    chk("sb_bounce", bounce, e.bn);
    chk("sb_miss", miss, e.ms);
  endtask

  task automatic tk();
    step(1'b1, 1'b0, 1'b0, g_px, g_pw);
    step(1'b0, 1'b0, 1'b0, g_px, g_pw);
  endtask

  task automatic run_to(input int ty);
    int n = 0;
    while (!(m_st == 1 && m_dy == 1 && m_y == ty) && n < 4000) begin
      tk();
      n++;
    end
    chk("run_to_bound", (n < 4000) ? 1 : 0, 1);
  endtask

  task automatic run_to_miss();
    int n = 0;
    bit got = 1'b0;
    run_to(451);
    g_px = (m_x < 300) ? 600 : 0;
    g_pw = 16;
    while (!got && n < 100) begin
      step(1'b1, 1'b0, 1'b0, g_px, g_pw);
      got = (m_ms == 1);
      if (!got) step(1'b0, 1'b0, 1'b0, g_px, g_pw);
      n++;
    end
    chk("miss_pulse", miss, 1);
    chk("miss_nobounce", bounce, 0);
  endtask

  task automatic async_reset(input string tag);
    tick   = 1'b0;
    launch = 1'b0;
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    check_reset_vals(tag);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: time limit reached, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    srv_t tbl[7];
    int xs, ys, edx, x0;

    tbl = '{
      '{100,   64, 128},
      '{0,      4,   0},
      '{0,      8,   0},
      '{1000,  64, 632},
      '{300,    0, 296},
      '{1023, 1023, 632},
      '{600,   64, 628}
    };

    reset        = 1'b1;
    tick         = 1'b0;
    pause        = 1'b0;
    launch       = 1'b0;
    paddle_x     = '0;
    paddle_width = 10'd64;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    check_reset_vals("rst");
    reset = 1'b0;

    // Serve tracking table.
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 1'b0, 1'b0, tbl[i].px, tbl[i].pw);
      chk("serve_x", ball_x, tbl[i].ex);
      chk("serve_y", ball_y, 452);
      chk("serve_state", state, 0);
    end

    // Launch under pause is dropped.
    step(1'b1, 1'b1, 1'b1, 100, 64);
    chk("pause_serve_x", ball_x, 628);
    chk("pause_serve_state", state, 0);

    // Launch near the right wall.
    g_px = 600;
    g_pw = 64;
    step(1'b0, 1'b0, 1'b1, g_px, g_pw);
    chk("launch_state", state, 1);
    chk("launch_x", ball_x, 628);
    repeat (4) tk();
    chk("rwall_reach", ball_x, 632);
    tk();
    chk("rwall_clamp", ball_x, 632);
    tk();
    chk("rwall_back", ball_x, 631);

    // Ticks under pause are dropped.
    xs = m_x;
    ys = m_y;
    repeat (5) step(1'b1, 1'b1, 1'b0, g_px, g_pw);
    chk("pause_x", ball_x, xs);
    chk("pause_y", ball_y, ys);
    step(1'b1, 1'b0, 1'b0, g_px, g_pw);
    chk("unpause_x", ball_x, xs - 1);
    chk("unpause_y", ball_y, ys - 1);

    // Middle-of-paddle hit.
    run_to(451);
    tk();
    chk("pre_hit_y", ball_y, 452);
    chk("pre_hit_bounce", bounce, 0);
    g_px = (m_x >= 20) ? m_x - 20 : 0;
    g_pw = 64;
    step(1'b1, 1'b0, 1'b0, g_px, g_pw);
    chk("hit_bounce", bounce, 1);
    chk("hit_y", ball_y, 452);
    step(1'b0, 1'b0, 1'b0, g_px, g_pw);
    chk("hit_pulse_end", bounce, 0);
    tk();
    chk("hit_goes_up", ball_y, 451);

    run_to_miss();
    chk("miss1_lives", lives, 2);
    chk("miss1_state", state, 0);

    // Rally 2: outer-quarter hit.
    g_px = 300;
    g_pw = 64;
    step(1'b0, 1'b0, 1'b1, g_px, g_pw);
    chk("launch2_state", state, 1);
    run_to(451);
    tk();
    edx = 0;
    if (m_dx > 0 && m_x >= 4 && m_x <= 628) begin
      g_px = m_x - 1;
`ifdef BALL_ANGLE_EN
      edx = -2;
`else
      edx = 1;
`endif
    end else if (m_dx < 0 && m_x >= 59 && m_x <= 628) begin
      g_px = m_x - 59;
`ifdef BALL_ANGLE_EN
      edx = 2;
`else
      edx = -1;
`endif
    end else begin
      g_px = (m_x >= 20) ? m_x - 20 : 0;
    end
    g_pw = 64;
    step(1'b1, 1'b0, 1'b0, g_px, g_pw);
    chk("angle_bounce", bounce, 1);
    step(1'b0, 1'b0, 1'b0, g_px, g_pw);
    if (edx != 0 && m_x >= 4 && m_x <= 628) begin
      x0 = m_x;
      step(1'b1, 1'b0, 1'b0, g_px, g_pw);
      chk("angle_dx", int'(ball_x) - x0, edx);
    end

    run_to_miss();
    chk("miss2_lives", lives, 1);
    chk("miss2_state", state, 0);

    // Rally 3: last life.
    g_px = 100;
    g_pw = 64;
    step(1'b0, 1'b0, 1'b1, g_px, g_pw);
    run_to_miss();
    chk("miss3_lives", lives, 0);
    chk("miss3_state", state, 2);

    // OVER ignores launch and tick.
    xs = m_x;
    step(1'b0, 1'b0, 1'b1, 100, 64);
    repeat (3) tk();
    chk("over_state", state, 2);
    chk("over_lives", lives, 0);
    chk("over_x", ball_x, xs);

    async_reset("rst_over");

    // Reset in the middle of a rally.
    g_px = 200;
    g_pw = 64;
    step(1'b0, 1'b0, 1'b1, g_px, g_pw);
    chk("launch4_x", ball_x, 228);
    repeat (10) tk();
    chk("rally4_y", ball_y, 442);
    async_reset("rst_mid");
    step(1'b0, 1'b0, 1'b0, 100, 64);
    chk("post_rst_serve_x", ball_x, 128);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
